// File: rtl/tia_hmove_scheduler_if.sv
// rtl/tia_hmove_scheduler_if.sv - bus bundle between timing/register logic and the HMOVE scheduler
interface tia_hmove_scheduler_if;
  logic       line_start;
  logic       hmove;
  logic       hmclr;
  logic [4:0] hm_we;
  logic [3:0] hm_d;
  logic [4:0] motck;
  logic       hmove_blank;
  logic       busy;

  modport master (
    output line_start, hmove, hmclr, hm_we, hm_d,
    input  motck, hmove_blank, busy
  );

  modport slave (
    input  line_start, hmove, hmclr, hm_we, hm_d,
    output motck, hmove_blank, busy
  );
endinterface

// File: rtl/tia_hmove_scheduler.sv
// rtl/tia_hmove_scheduler.sv - HMOVE extra motion clock burst scheduler for P0,P1,M0,M1,BL
module tia_hmove_scheduler #(
  parameter int STEP_CLKS  = 4,
  parameter int NUM_STEPS  = 15,
  parameter int HBLANK_EXT = 8
) (
  input logic                   clk,
  input logic                   r,
  tia_hmove_scheduler_if.slave  bus
);

  localparam int SUB_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int HB_W  = (HBLANK_EXT > 1) ? $clog2(HBLANK_EXT) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(STEP_CLKS - 1);
  localparam logic [3:0]       STEP_LAST = 4'(NUM_STEPS - 1);
  localparam logic [HB_W-1:0]  HB_LOAD   = HB_W'(HBLANK_EXT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_hm  [5];
  logic [3:0]       r_ext [5];
  logic             r_pending;
  logic [3:0]       r_step;
  logic [SUB_W-1:0] r_sub;
  logic [4:0]       r_motck;
  logic             r_hblank;
  logic [HB_W-1:0]  r_hb_cnt;

  logic             w_run_entry;
  logic             w_burst_end;
  logic             w_sub_wrap;
  logic [4:0]       w_motck_nxt;

  assign w_sub_wrap = (r_sub == SUB_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (r) r_state <= ST_IDLE;
    else   r_state <= w_state_nxt;
  end

  // Next-state decode; a second hmove while armed is absorbed, hmove while running queues another burst
  always_comb begin
    w_state_nxt = r_state;
    w_run_entry = 1'b0;
    w_burst_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.hmove) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.line_start) begin
          w_state_nxt = ST_RUN;
          w_run_entry = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_sub_wrap && (r_step == STEP_LAST)) begin
          w_burst_end = 1'b1;
          w_state_nxt = (r_pending || bus.hmove) ? ST_ARMED : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Motion registers; hmclr takes priority over a same-cycle write
  always_ff @(posedge clk) begin
    if (r || bus.hmclr) begin
      for (int i = 0; i < 5; i++) r_hm[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (bus.hm_we[i]) r_hm[i] <= bus.hm_d;
      end
    end
  end

  // Burst counters and snapshot of extra-clock counts (value+8, i.e. MSB inverted)
  always_ff @(posedge clk) begin
    if (r) begin
      for (int i = 0; i < 5; i++) r_ext[i] <= 4'd0;
      r_step    <= 4'd0;
      r_sub     <= '0;
      r_pending <= 1'b0;
    end else if (w_run_entry) begin
      for (int i = 0; i < 5; i++) r_ext[i] <= {~r_hm[i][3], r_hm[i][2:0]};
      r_step    <= 4'd0;
      r_sub     <= '0;
      r_pending <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_burst_end) begin
        r_step    <= 4'd0;
        r_sub     <= '0;
        r_pending <= 1'b0;
      end else begin
        if (bus.hmove) r_pending <= 1'b1;
        if (w_sub_wrap) begin
          r_sub  <= '0;
          r_step <= r_step + 4'd1;
        end else begin
          r_sub <= r_sub + SUB_W'(1);
        end
      end
    end
  end

  // One extra clock per step at sub 0 while the step index is below the object's count
  always_comb begin
    w_motck_nxt = 5'd0;
    for (int i = 0; i < 5; i++) begin
      w_motck_nxt[i] = (r_state == ST_RUN) && (r_sub == '0) && (r_step < r_ext[i]);
    end
  end

  // Registered motion clock outputs
  always_ff @(posedge clk) begin
    if (r) r_motck <= 5'd0;
    else   r_motck <= w_motck_nxt;
  end

  // Extended hblank: fixed-length window from burst start, independent of burst length
  always_ff @(posedge clk) begin
    if (r) begin
      r_hblank <= 1'b0;
      r_hb_cnt <= '0;
    end else if (w_run_entry) begin
      r_hblank <= 1'b1;
      r_hb_cnt <= HB_LOAD;
    end else if (r_hblank) begin
      if (r_hb_cnt == '0) r_hblank <= 1'b0;
      else                r_hb_cnt <= r_hb_cnt - HB_W'(1);
    end
  end

  assign bus.motck       = r_motck;
  assign bus.hmove_blank = r_hblank;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tia_hmove_scheduler.sv
// tb/tb_tia_hmove_scheduler.sv - directed self-checking bench for tia_hmove_scheduler
module tb_tia_hmove_scheduler;

  logic clk;
  logic r;
  int   n_checks;
  int   n_errors;

  tia_hmove_scheduler_if bus ();

  tia_hmove_scheduler #(
    .STEP_CLKS  (4),
    .NUM_STEPS  (15),
    .HBLANK_EXT (8)
  ) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_hm(input logic [4:0] we, input logic [3:0] d);
    bus.hm_we = we;
    bus.hm_d  = d;
    tick();
    bus.hm_we = 5'd0;
    bus.hm_d  = 4'd0;
  endtask

  task automatic pulse_hmove;
    bus.hmove = 1'b1;
    tick();
    bus.hmove = 1'b0;
  endtask

  task automatic pulse_hmclr;
    bus.hmclr = 1'b1;
    tick();
    bus.hmclr = 1'b0;
  endtask

  // Run n cycles expecting no motion clocks and no extended blank
  task automatic quiet(input string tag, input int n, input logic exp_busy);
    int n_mot;
    int n_blank;
    int n_busy_bad;
    n_mot = 0; n_blank = 0; n_busy_bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.motck != 5'd0) n_mot++;
      if (bus.hmove_blank) n_blank++;
      if (bus.busy !== exp_busy) n_busy_bad++;
    end
    check({tag, "_motck"}, n_mot, 0);
    check({tag, "_blank"}, n_blank, 0);
    check({tag, "_busy"}, n_busy_bad, 0);
  endtask

  // Pulse line_start and watch 71 samples (k=0 right after the RUN-entry edge).
  // act_kind 1: write M0=F together with hmclr; 2: hmove. Driven so it is sampled at edge act_k+1.
  task automatic observe(input string tag, input logic [19:0] exts, input int act_k,
                         input int act_kind, input int exp_fall);
    int cnt [5];
    int pos_err [5];
    int blank_bad;
    int busy_fall;
    logic [3:0] e;
    for (int i = 0; i < 5; i++) begin cnt[i] = 0; pos_err[i] = 0; end
    blank_bad = 0;
    busy_fall = 99;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) begin
        if (k - 1 == act_k) begin
          if (act_kind == 1) begin
            bus.hm_we = 5'b00100; bus.hm_d = 4'hF; bus.hmclr = 1'b1;
          end else if (act_kind == 2) begin
            bus.hmove = 1'b1;
          end
        end
        tick();
        bus.hm_we = 5'd0; bus.hm_d = 4'd0; bus.hmclr = 1'b0; bus.hmove = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        e = exts[i*4 +: 4];
        if (bus.motck[i]) begin
          cnt[i]++;
          if (!((k % 4 == 1) && ((k - 1) / 4 < int'(e)))) pos_err[i]++;
        end
      end
      if (bus.hmove_blank !== (k < 8)) blank_bad++;
      if (!bus.busy && busy_fall == 99) busy_fall = k;
    end
    for (int i = 0; i < 5; i++) begin
      e = exts[i*4 +: 4];
      check($sformatf("%s_cnt%0d", tag, i), cnt[i], {28'd0, e});
      check($sformatf("%s_pos%0d", tag, i), pos_err[i], 0);
    end
    check({tag, "_blank"}, blank_bad, 0);
    check({tag, "_busy_fall"}, busy_fall, exp_fall);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.line_start = 1'b0;
    bus.hmove      = 1'b0;
    bus.hmclr      = 1'b0;
    bus.hm_we      = 5'd0;
    bus.hm_d       = 4'd0;
    r              = 1'b1;

    // 1: reset
    tick();
    tick();
    check("rst_motck", bus.motck, 0);
    check("rst_blank", bus.hmove_blank, 0);
    check("rst_busy", bus.busy, 0);
    r = 1'b0;
    quiet("idle100", 100, 1'b0);

    // 2: P0=+7 (15 clocks), P1=-8 (0 clocks), others 0 (8 clocks)
    write_hm(5'b00001, 4'h7);
    write_hm(5'b00010, 4'h8);
    pulse_hmove();
    observe("t2", {4'd8, 4'd8, 4'd8, 4'd0, 4'd15}, -10, 0, 60);

    // 3: hmclr, then hmove with line_start in the same idle cycle arms only
    pulse_hmclr();
    bus.hmove = 1'b1;
    bus.line_start = 1'b1;
    tick();
    bus.hmove = 1'b0;
    bus.line_start = 1'b0;
    check("t3_armed_busy", bus.busy, 1);
    quiet("t3_armed", 10, 1'b1);
    observe("t3", {4'd8, 4'd8, 4'd8, 4'd8, 4'd8}, -10, 0, 60);

    // 4: M0=3 (11 clocks); mid-burst M0=F write with hmclr must not disturb it
    write_hm(5'b00100, 4'h3);
    pulse_hmove();
    observe("t4a", {4'd8, 4'd8, 4'd11, 4'd8, 4'd8}, 8, 1, 60);
    pulse_hmove();
    observe("t4b", {4'd8, 4'd8, 4'd8, 4'd8, 4'd8}, -10, 0, 60);

    // 5: hmove at step 5 queues a second burst
    pulse_hmove();
    observe("t5a", {4'd8, 4'd8, 4'd8, 4'd8, 4'd8}, 20, 2, 99);
    quiet("t5_gap", 10, 1'b1);
    observe("t5b", {4'd8, 4'd8, 4'd8, 4'd8, 4'd8}, -10, 0, 60);

    // 6: reset at step 7 aborts the burst
    pulse_hmove();
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    for (int k = 0; k < 28; k++) tick();
    r = 1'b1;
    tick();
    check("t6_motck", bus.motck, 0);
    check("t6_blank", bus.hmove_blank, 0);
    check("t6_busy", bus.busy, 0);
    r = 1'b0;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    quiet("t6_after", 70, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
